pipeline_sequencer: RTL and testbench

// - Run-control FSM for the 5-stage MIPS pipeline: gates IF/ID advance (RUN, single STEP, HALT) from debug commands.
// - Detects the HALT opcode reported by decode and freezes the pipeline in DONE.
// - Shares register-file read port 1 between decode (rs) and a debug dump that streams all registers out.
// - Sits between the debug/UART command path and the IF/ID stages; the regfile port-1 mux lives outside and is steered by o_dbg_sel.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/pipeline_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline control blocks.
// Contents:
//   - debug command codes (RUN / STEP / DUMP / HALT)
//   - run-control FSM state encodings (also driven out on o_state)
//   - HALT opcode value recognised by decode
//   - helper deciding in which states a debug command is accepted
package mips_pkg;

    // Debug command codes on i_cmd
    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_STEP = 2'b01;
    localparam logic [1:0] CMD_DUMP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    // Run-control FSM states; values are visible to the debugger
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_DUMP_RD = 3'd3;
    localparam logic [2:0] ST_DUMP_TX = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Primary opcode field that decode flags as HALT
    localparam logic [5:0] OP_HALT = 6'h3f;

    // Commands are only taken while the FSM is in a resting state
    function automatic logic cmd_ready_in(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer for the 5-stage MIPS pipeline.
// Gates pipeline advance from debug commands (RUN, single STEP, HALT), freezes the
// core in DONE when decode reports the HALT opcode, and streams the register file
// out through a valid/ready port on a DUMP command by borrowing regfile read port 1.
// Ports:
//   clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd     debug command (see mips_pkg CMD_*), o_cmd_ready acknowledges
//   i_halt_instr          decode holds the HALT opcode this cycle
//   i_load_use            load-use hazard from decode
//   o_stall               freezes PC, IF/ID and ID/EX
//   o_dbg_sel             steers the external regfile port-1 mux to o_dbg_rd_addr
//   o_dbg_rd_addr         debug read address
//   i_rd_data1            regfile port-1 read data (combinational read)
//   o_dump_*/i_dump_ready dump word stream (addr + data) with handshake
//   o_state               FSM state code
//   o_cycle_count         number of cycles in which the pipeline advanced
module pipeline_sequencer
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int NB_CYC  = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_halt_instr,
    input  logic               i_load_use,
    output logic               o_stall,
    output logic               o_dbg_sel,
    output logic [NB_ADDR-1:0] o_dbg_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data1,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    input  logic               i_dump_ready,
    output logic [2:0]         o_state,
    output logic [NB_CYC-1:0]  o_cycle_count
);

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    logic [2:0]         state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic               ret_done_q, ret_done_d;  // 1: dump returns to DONE, 0: to IDLE
    logic               dump_valid_q, dump_valid_d;
    logic [NB_ADDR-1:0] dump_addr_q, dump_addr_d;
    logic [NB_DATA-1:0] dump_data_q, dump_data_d;
    logic [NB_CYC-1:0]  cycle_count_q, cycle_count_d;

    logic cmd_ready;
    logic cmd_accept;
    logic stall;

    assign cmd_ready  = cmd_ready_in(state_q);
    assign cmd_accept = i_cmd_valid && cmd_ready;
    // Hazard stall is combined here so ID sees a single freeze signal
    assign stall      = !((state_q == ST_RUN) || (state_q == ST_STEP)) || i_load_use;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ret_done_d    = ret_done_q;
        dump_valid_d  = dump_valid_q;
        dump_addr_d   = dump_addr_q;
        dump_data_d   = dump_data_q;
        cycle_count_d = stall ? cycle_count_q : cycle_count_q + NB_CYC'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (i_cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: begin
                            state_d    = ST_DUMP_RD;
                            ret_done_d = 1'b0;
                        end
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // HALT opcode wins over a simultaneous HALT command
                if (i_halt_instr) begin
                    state_d = ST_DONE;
                end else if (cmd_accept && (i_cmd == CMD_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                // Held while the hazard stalls; the first clean cycle is the step
                if (i_halt_instr) begin
                    state_d = ST_DONE;
                end else if (!i_load_use) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DUMP_RD: begin
                dump_valid_d = 1'b1;
                dump_addr_d  = idx_q;
                dump_data_d  = i_rd_data1;
                state_d      = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                if (i_dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ret_done_q ? ST_DONE : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + NB_ADDR'(1);
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            ST_DONE: begin
                if (cmd_accept && (i_cmd == CMD_DUMP)) begin
                    state_d    = ST_DUMP_RD;
                    ret_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            ret_done_q    <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_addr_q   <= '0;
            dump_data_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ret_done_q    <= ret_done_d;
            dump_valid_q  <= dump_valid_d;
            dump_addr_q   <= dump_addr_d;
            dump_data_q   <= dump_data_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Port 1 is borrowed for the whole dump, released as soon as the FSM leaves it
    assign o_dbg_sel     = (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_TX);
    assign o_dbg_rd_addr = idx_q;
    assign o_cmd_ready   = cmd_ready;
    assign o_stall       = stall;
    assign o_dump_valid  = dump_valid_q;
    assign o_dump_addr   = dump_addr_q;
    assign o_dump_data   = dump_data_q;
    assign o_state       = state_q;
    assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios followed by random
// command/hazard/ready traffic, all checked every cycle against a behavioural model.
module tb_pipeline_sequencer;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int N_REGS  = 32;
    localparam int NB_CYC  = 32;

    // Mode numbers are the debugger-visible state codes
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_RD = 3, M_TX = 4, M_DONE = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic [1:0]         cmd;
    logic               cmd_ready;
    logic               halt_instr;
    logic               load_use;
    logic               stall;
    logic               dbg_sel;
    logic [NB_ADDR-1:0] dbg_rd_addr;
    logic [NB_DATA-1:0] rd_data1;
    logic               dump_valid;
    logic [NB_ADDR-1:0] dump_addr;
    logic [NB_DATA-1:0] dump_data;
    logic               dump_ready;
    logic [2:0]         state;
    logic [NB_CYC-1:0]  cycle_count;

    logic [NB_DATA-1:0] rf [N_REGS];

    always #5 clk = ~clk;

    // External port-1 mux: garbage unless the sequencer owns the port
    assign rd_data1 = dbg_sel ? rf[dbg_rd_addr] : 32'hdead_beef;

    pipeline_sequencer #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR),
        .N_REGS (N_REGS),
        .NB_CYC (NB_CYC)
    ) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .o_cmd_ready  (cmd_ready),
        .i_halt_instr (halt_instr),
        .i_load_use   (load_use),
        .o_stall      (stall),
        .o_dbg_sel    (dbg_sel),
        .o_dbg_rd_addr(dbg_rd_addr),
        .i_rd_data1   (rd_data1),
        .o_dump_valid (dump_valid),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .i_dump_ready (dump_ready),
        .o_state      (state),
        .o_cycle_count(cycle_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hs_count = 0;

    // Reference model
    int                 m_mode;
    bit                 m_ret_done;
    int                 m_idx;
    logic               m_valid;
    logic [NB_ADDR-1:0] m_addr;
    logic [NB_DATA-1:0] m_data;
    logic [NB_CYC-1:0]  m_count;

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_ret_done = 1'b0;
        m_idx      = 0;
        m_valid    = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_count    = '0;
    endtask

    // One clock: compare at the falling edge, advance the model, return after the edge
    task automatic step();
        bit exp_stall, exp_ready, accept;
        @(negedge clk);
        exp_stall = !(m_mode == M_RUN || m_mode == M_STEP) || load_use;
        exp_ready = (m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_DONE);
        check_value("state", state, m_mode);
        check_value("stall", stall, exp_stall);
        check_value("cmd_ready", cmd_ready, exp_ready);
        check_value("dbg_sel", dbg_sel, (m_mode == M_RD) || (m_mode == M_TX));
        check_value("dbg_rd_addr", dbg_rd_addr, m_idx);
        check_value("dump_valid", dump_valid, m_valid);
        check_value("dump_addr", dump_addr, m_addr);
        check_value("dump_data", dump_data, m_data);
        check_value("cycle_count", cycle_count, m_count);
        if (dump_valid && dump_ready) hs_count++;

        accept = cmd_valid && exp_ready;
        if (!exp_stall) m_count = m_count + 1'b1;
        case (m_mode)
            M_IDLE: if (accept) begin
                if (cmd == 2'd0) m_mode = M_RUN;
                else if (cmd == 2'd1) m_mode = M_STEP;
                else if (cmd == 2'd2) begin
                    m_mode     = M_RD;
                    m_ret_done = 1'b0;
                end
            end
            M_RUN: begin
                if (halt_instr) m_mode = M_DONE;
                else if (accept && cmd == 2'd3) m_mode = M_IDLE;
            end
            M_STEP: begin
                if (halt_instr) m_mode = M_DONE;
                else if (!load_use) m_mode = M_IDLE;
            end
            M_RD: begin
                m_valid = 1'b1;
                m_addr  = NB_ADDR'(m_idx);
                m_data  = rf[m_idx];
                m_mode  = M_TX;
            end
            M_TX: if (dump_ready) begin
                m_valid = 1'b0;
                if (m_idx == N_REGS - 1) begin
                    m_idx  = 0;
                    m_mode = m_ret_done ? M_DONE : M_IDLE;
                end else begin
                    m_idx  = m_idx + 1;
                    m_mode = M_RD;
                end
            end
            M_DONE: if (accept && cmd == 2'd2) begin
                m_mode     = M_RD;
                m_ret_done = 1'b1;
            end
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        cmd_valid  = 1'b0;
        cmd        = 2'd0;
        halt_instr = 1'b0;
        load_use   = 1'b0;
        dump_ready = 1'b1;
        for (int k = 0; k < N_REGS; k++) rf[k] = 32'(k * 3);
        do_reset();
        check_value("reset_count", cycle_count, 0);
        check_value("reset_stall", stall, 1);

        // RUN for 10 cycles, then HALT command
        send_cmd(2'd0);
        repeat (10) step();
        check_value("run10_count", cycle_count, 10);
        send_cmd(2'd3);
        check_value("halt_count", cycle_count, 11);
        check_value("halt_state", state, M_IDLE);
        check_value("halt_stall", stall, 1);

        // STEP held by load-use for two cycles
        load_use = 1'b1;
        send_cmd(2'd1);
        repeat (2) step();
        check_value("step_held", cycle_count, 11);
        load_use = 1'b0;
        step();
        check_value("step_count", cycle_count, 12);
        check_value("step_state", state, M_IDLE);

        // HALT opcode and HALT command together -> DONE; later RUN is ignored
        send_cmd(2'd0);
        halt_instr = 1'b1;
        send_cmd(2'd3);
        halt_instr = 1'b0;
        check_value("done_state", state, M_DONE);
        send_cmd(2'd0);
        check_value("done_sticky", state, M_DONE);

        // Full dump from DONE with sink always ready
        hs_count = 0;
        send_cmd(2'd2);
        cyc = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            cyc++;
            if (state == 3'd5) break;
        end
        check_value("dump_cycles", cyc, 2 * N_REGS);
        check_value("dump_words", hs_count, N_REGS);
        check_value("dump_sel_off", dbg_sel, 0);

        // Backpressure on word 7
        hs_count = 0;
        send_cmd(2'd2);
        for (int c = 0; c < 100; c++) begin
            if (dump_valid && dump_addr == 5'd7) break;
            step();
        end
        dump_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_value("bp_valid", dump_valid, 1);
            check_value("bp_addr", dump_addr, 7);
            check_value("bp_data", dump_data, 21);
        end
        dump_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (state == 3'd5) break;
            step();
        end
        check_value("bp_words", hs_count, N_REGS);
        check_value("bp_state", state, M_DONE);

        // Asynchronous reset in the middle of word 12
        do_reset();
        send_cmd(2'd2);
        for (int c = 0; c < 100; c++) begin
            if (dump_valid && dump_addr == 5'd12) break;
            step();
        end
        dump_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_value("arst_valid", dump_valid, 0);
        check_value("arst_sel", dbg_sel, 0);
        check_value("arst_state", state, M_IDLE);
        check_value("arst_stall", stall, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dump_ready = 1'b1;
        step();
        check_value("arst_after", state, M_IDLE);

        // Random traffic with periodic resets
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(0, 1) == 1);
            cmd        = 2'($urandom_range(0, 3));
            load_use   = ($urandom_range(0, 3) == 0);
            halt_instr = ($urandom_range(0, 39) == 0);
            dump_ready = ($urandom_range(0, 9) < 7);
            if (i % 500 == 499) begin
                for (int k = 0; k < N_REGS; k++) rf[k] = $urandom;
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
